cascade_counter: RTL and testbench

CASCADE_COUNTER -- requirements
Module: cascade_counter

---
 rtl/cascade_counter_pkg.sv | 25 ++
 rtl/mod_digit.sv | 62 ++++++
 rtl/cascade_counter.sv | 105 ++++++++++
 tb/tb_cascade_counter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cascade_counter_pkg
// Description : Shared defaults and helpers for the cascaded modulo counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cascade_counter_pkg;

  // Default chain: mm:ss style, digit 0 in the LSBs (mod 10, 6, 10, 6)
  localparam int unsigned c_DEF_DIGITS = 4;
  localparam int unsigned c_DEF_DW     = 4;
  localparam logic [c_DEF_DIGITS*c_DEF_DW-1:0] c_DEF_MOD_VEC = {4'd6, 4'd10, 4'd6, 4'd10};

  // Bit position of digit k inside a packed DIGITS*DW vector
  function automatic int unsigned digit_lsb(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

  // A DW-bit modulus field cannot hold 2^DW, so a field of 0 encodes 2^DW
  function automatic int unsigned field_to_mod(input int unsigned field, input int unsigned dw);
    return (field == 0) ? (32'd1 << dw) : field;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_digit.sv
`default_nettype none
// ============================================================================
// Module      : mod_digit
// Description : One modulo-MOD digit with step/load/clear and boundary flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_digit #(
  parameter int DW  = 4,
  parameter int MOD = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          up_dn,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] value,
  output logic          at_max,
  output logic          at_zero,
  output logic          load_clamp
);

  // Compare in DW+1 bits so a modulus of 2^DW never clamps
  localparam logic [DW:0]   c_MOD = (DW+1)'(MOD);
  localparam logic [DW-1:0] c_MAX = DW'(MOD - 1);

  logic [DW-1:0] r_value;
  logic [DW-1:0] w_next;
  logic [DW-1:0] w_load_val;

  assign at_max     = (r_value == c_MAX);
  assign at_zero    = (r_value == '0);
  assign load_clamp = ({1'b0, load_val} >= c_MOD);
  assign w_load_val = load_clamp ? c_MAX : load_val;
  assign value      = r_value;

  // Next value when stepping: wrap at the modulus boundary in either direction
  always_comb begin
    w_next = r_value;
    if (up_dn) begin
      w_next = at_max ? '0 : r_value + DW'(1);
    end else begin
      w_next = at_zero ? c_MAX : r_value - DW'(1);
    end
  end

  // Digit register: clear beats load beats step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (clear) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= w_load_val;
    end else if (step) begin
      r_value <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cascade_counter.sv
`default_nettype none
// ============================================================================
// Module      : cascade_counter
// Description : DIGITS cascaded modulo digits, up/down, with wrap/ovf/load_err.
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int                    DIGITS  = c_DEF_DIGITS,
  parameter int                    DW      = c_DEF_DW,
  parameter logic [DIGITS*DW-1:0]  MOD_VEC = c_DEF_MOD_VEC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic                 en,
  input  logic                 up_dn,
  output logic [DIGITS*DW-1:0] count,
  output logic                 wrap,
  output logic                 ovf,
  output logic                 load_err
);

  // w_all_max[k]/w_all_zero[k]: digits 0..k-1 are all at max / all at zero
  logic [DIGITS:0]   w_all_max;
  logic [DIGITS:0]   w_all_zero;
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_zero;
  logic [DIGITS-1:0] w_step;
  logic [DIGITS-1:0] w_clamp;
  logic              w_count_en;
  logic              w_digit_load;
  logic              w_wrap_now;

  logic r_wrap;
  logic r_ovf;
  logic r_load_err;

  // Lower-priority actions are masked here so only one acts per cycle
  assign w_count_en   = en & ~clear & ~load;
  assign w_digit_load = load & ~clear;

  assign w_all_max[0]  = 1'b1;
  assign w_all_zero[0] = 1'b1;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      localparam logic [DW-1:0] c_FIELD = MOD_VEC[digit_lsb(k, DW) +: DW];
      localparam int            c_MOD   = int'(field_to_mod(int'(c_FIELD), DW));

      assign w_all_max[k+1]  = w_all_max[k]  & w_at_max[k];
      assign w_all_zero[k+1] = w_all_zero[k] & w_at_zero[k];
      assign w_step[k]       = w_count_en & (up_dn ? w_all_max[k] : w_all_zero[k]);

      mod_digit #(
        .DW  (DW),
        .MOD (c_MOD)
      ) u_digit (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (w_step[k]),
        .up_dn      (up_dn),
        .clear      (clear),
        .load       (w_digit_load),
        .load_val   (load_val[k*DW +: DW]),
        .value      (count[k*DW +: DW]),
        .at_max     (w_at_max[k]),
        .at_zero    (w_at_zero[k]),
        .load_clamp (w_clamp[k])
      );
    end
  endgenerate

  // Whole chain rolls over when every digit sits at the boundary being left
  assign w_wrap_now = w_count_en & (up_dn ? w_all_max[DIGITS] : w_all_zero[DIGITS]);

  // Status flags: wrap and load_err are single-cycle pulses, ovf is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap     <= 1'b0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else if (clear) begin
      r_wrap     <= 1'b0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_wrap     <= 1'b0;
      r_load_err <= |w_clamp;
    end else begin
      r_wrap     <= w_wrap_now;
      r_ovf      <= r_ovf | w_wrap_now;
      r_load_err <= 1'b0;
    end
  end

  assign wrap     = r_wrap;
  assign ovf      = r_ovf;
  assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cascade_counter
// Description : Self-checking bench for cascade_counter with default moduli.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cascade_counter;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        up_dn;
  logic [15:0] count;
  logic        wrap;
  logic        ovf;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: the counter is one integer 0..3599 in mixed radix
  int mods[4] = '{10, 6, 10, 6};
  localparam int c_RANGE = 3600;
  int m_total;
  bit m_wrap;
  bit m_ovf;
  bit m_err;

  cascade_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up_dn    (up_dn),
    .count    (count),
    .wrap     (wrap),
    .ovf      (ovf),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] to_packed(input int t);
    logic [15:0] r;
    int v;
    v = t;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(v % mods[k]);
      v = v / mods[k];
    end
    return r;
  endfunction

  // Apply the current inputs to the model, then advance one clock
  task automatic tick();
    int  t;
    int  d;
    bit  e;
    if (clear) begin
      m_total = 0; m_wrap = 0; m_ovf = 0; m_err = 0;
    end else if (load) begin
      t = 0; e = 0;
      for (int k = 3; k >= 0; k--) begin
        d = int'(load_val[k*4 +: 4]);
        if (d >= mods[k]) begin
          d = mods[k] - 1;
          e = 1;
        end
        t = t * mods[k] + d;
      end
      m_total = t; m_wrap = 0; m_err = e;
    end else if (en) begin
      if (up_dn) begin
        m_wrap  = (m_total == c_RANGE - 1);
        m_total = (m_total + 1) % c_RANGE;
      end else begin
        m_wrap  = (m_total == 0);
        m_total = (m_total + c_RANGE - 1) % c_RANGE;
      end
      m_ovf = m_ovf | m_wrap;
      m_err = 0;
    end else begin
      m_wrap = 0; m_err = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; load = 0; en = 0; up_dn = 1; load_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    m_total = 0; m_wrap = 0; m_ovf = 0; m_err = 0;
    #3;
    checks++;
    if ({count, wrap, ovf, load_err} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state: got count=%h wrap=%b ovf=%b err=%b want all 0", count, wrap, ovf, load_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_cycle();
    int wrap_cnt = 0;
    int wrap_at  = -1;
    int bad      = 0;
    en = 1; up_dn = 1;
    for (int i = 1; i <= 3600; i++) begin
      tick();
      if (wrap === 1'b1) begin
        wrap_cnt++;
        wrap_at = i;
      end
      if (count !== to_packed(m_total)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL full_cycle_track: %0d cycles wrong count, want 0", bad);
    end
    checks++;
    if (wrap_cnt !== 1 || wrap_at !== 3600) begin
      failures++;
      $display("FAIL full_cycle_wrap: %0d pulses at cycle %0d, want 1 at 3600", wrap_cnt, wrap_at);
    end
    checks++;
    if (count !== 16'h0000 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL full_cycle_end: count=%h ovf=%b, want 0000 ovf=1", count, ovf);
    end
    en = 0;
    tick();
    checks++;
    if (wrap !== 1'b0 || count !== 16'h0000) begin
      failures++;
      $display("FAIL hold: count=%h wrap=%b, want 0000 wrap=0", count, wrap);
    end
  endtask

  task automatic test_load_wrap_up();
    load = 1; load_val = 16'h5959; en = 1; up_dn = 1;
    tick();
    load = 0;
    checks++;
    if (count !== 16'h5959 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_5959: count=%h wrap=%b, want 5959 wrap=0", count, wrap);
    end
    tick();
    checks++;
    if (count !== 16'h0000 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL up_wrap: count=%h wrap=%b, want 0000 wrap=1", count, wrap);
    end
    tick();
    checks++;
    if (count !== 16'h0001 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL up_after_wrap: count=%h wrap=%b, want 0001 wrap=0", count, wrap);
    end
    en = 0;
  endtask

  task automatic test_load_wrap_down();
    load = 1; load_val = 16'h0000; en = 1; up_dn = 0;
    tick();
    load = 0;
    tick();
    checks++;
    if (count !== 16'h5959 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap: count=%h wrap=%b, want 5959 wrap=1", count, wrap);
    end
    tick();
    checks++;
    if (count !== 16'h5958 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL down_after_wrap: count=%h wrap=%b, want 5958 wrap=0", count, wrap);
    end
    en = 0; up_dn = 1;
  endtask

  task automatic test_load_clamp();
    load = 1; load_val = 16'h7A9F;
    tick();
    load = 0;
    checks++;
    if (count !== 16'h5959 || load_err !== 1'b1) begin
      failures++;
      $display("FAIL load_clamp: count=%h err=%b, want 5959 err=1", count, load_err);
    end
    tick();
    checks++;
    if (load_err !== 1'b0 || count !== 16'h5959) begin
      failures++;
      $display("FAIL load_err_pulse: count=%h err=%b, want 5959 err=0", count, load_err);
    end
    load = 1; load_val = 16'h3049;
    tick();
    load = 0;
    checks++;
    if (count !== 16'h3049 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_inrange: count=%h err=%b, want 3049 err=0", count, load_err);
    end
  endtask

  task automatic test_clear_priority();
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b, want 1", ovf);
    end
    clear = 1; load = 1; en = 1; load_val = 16'h7A9F;
    tick();
    clear = 0; load = 0; en = 0;
    checks++;
    if ({count, wrap, ovf, load_err} !== 19'd0) begin
      failures++;
      $display("FAIL clear_priority: count=%h wrap=%b ovf=%b err=%b want all 0", count, wrap, ovf, load_err);
    end
  endtask

  task automatic test_async_reset();
    load = 1; load_val = 16'h5959;
    tick();
    load = 0; en = 1; up_dn = 1;
    tick();
    en = 0; load = 1; load_val = 16'h1234;
    tick();
    load = 0;
    checks++;
    if (count !== 16'h1234 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: count=%h ovf=%b, want 1234 ovf=1", count, ovf);
    end
    @(negedge clk);
    #1;
    rst_n = 0;
    m_total = 0; m_wrap = 0; m_ovf = 0; m_err = 0;
    #1;
    checks++;
    if ({count, wrap, ovf, load_err} !== 19'd0) begin
      failures++;
      $display("FAIL async_reset: count=%h wrap=%b ovf=%b err=%b want all 0", count, wrap, ovf, load_err);
    end
    @(negedge clk);
    rst_n = 1;
    en = 1; up_dn = 1;
    tick();
    en = 0;
    checks++;
    if (count !== 16'h0001) begin
      failures++;
      $display("FAIL resume_after_reset: count=%h, want 0001", count);
    end
  endtask

  task automatic test_random();
    int bad_cnt  = 0;
    int bad_wrap = 0;
    int bad_ovf  = 0;
    int bad_err  = 0;
    int wraps    = 0;
    int sel;
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 11) == 0);
      sel   = $urandom_range(0, 2);
      load_val = (sel == 0) ? 16'($urandom) : (sel == 1) ? 16'h5958 : 16'h0001;
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) up_dn = $urandom_range(0, 1);
      tick();
      if (wrap === 1'b1) wraps++;
      if (count    !== to_packed(m_total)) bad_cnt++;
      if (wrap     !== m_wrap)             bad_wrap++;
      if (ovf      !== m_ovf)              bad_ovf++;
      if (load_err !== m_err)              bad_err++;
    end
    idle_inputs();
    checks++;
    if (bad_cnt !== 0) begin
      failures++;
      $display("FAIL random_count: %0d cycles wrong, want 0", bad_cnt);
    end
    checks++;
    if (bad_wrap !== 0) begin
      failures++;
      $display("FAIL random_wrap: %0d cycles wrong, want 0", bad_wrap);
    end
    checks++;
    if (bad_ovf !== 0) begin
      failures++;
      $display("FAIL random_ovf: %0d cycles wrong, want 0", bad_ovf);
    end
    checks++;
    if (bad_err !== 0) begin
      failures++;
      $display("FAIL random_load_err: %0d cycles wrong, want 0", bad_err);
    end
    $display("random phase observed %0d wrap pulses", wraps);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_full_cycle();
    test_load_wrap_up();
    test_load_wrap_down();
    test_load_clamp();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
